// File: rtl/id.sv
// RV32I instruction-decode stage: register file, immediate generation,
// ALU operation select and the ID/EX pipeline register.
module id (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWrite,
  input  logic [4:0]  rd_WB,
  input  logic [31:0] Data_WB,
  input  logic [31:0] instrCode,
  input  logic [31:0] PC,
  output logic        read_data_valid,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] immOut,
  output logic [31:0] Read1,
  output logic [31:0] Read2,
  output logic [4:0]  rd,
  output logic [2:0]  func3,
  output logic [6:0]  opcode
  ,
  output logic [31:0] PC_ID
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  logic [31:0] regs [0:31];

  logic [6:0]  op;
  logic [2:0]  f3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        b30;

  logic is_r, is_iop, is_ld, is_st, is_br;
  logic is_jal, is_jalr, is_lui, is_aui;

  logic        valid_d;
  logic [3:0]  alu_d;
  logic [31:0] imm_d;
  logic [31:0] rd1_d;
  logic [31:0] rd2_d;

  assign op  = instrCode[6:0];
  assign f3  = instrCode[14:12];
  assign rs1 = instrCode[19:15];
  assign rs2 = instrCode[24:20];
  assign b30 = instrCode[30];

  assign is_r    = (op == OP_R);
  assign is_iop  = (op == OP_IALU);
  assign is_ld   = (op == OP_LOAD);
  assign is_st   = (op == OP_STORE);
  assign is_br   = (op == OP_BR);
  assign is_jal  = (op == OP_JAL);
  assign is_jalr = (op == OP_JALR);
  assign is_lui  = (op == OP_LUI);
  assign is_aui  = (op == OP_AUIPC);

  assign valid_d = is_r | is_iop | is_ld | is_st | is_br
                 | is_jal | is_jalr | is_lui | is_aui;

  // func3 to ALU op; sub_ok lets bit30 pick SUB (R-type only)
  function automatic logic [3:0] f3_alu(
    input logic [2:0] f,
    input logic       b,
    input logic       sub_ok
  );
    logic [3:0] a;
    a = ALU_ADD;
    unique case (f)
      3'b000: a = (sub_ok && b) ? ALU_SUB : ALU_ADD;
      3'b001: a = ALU_SLL;
      3'b010: a = ALU_SLT;
      3'b011: a = ALU_SLTU;
      3'b100: a = ALU_XOR;
      3'b101: a = b ? ALU_SRA : ALU_SRL;
      3'b110: a = ALU_OR;
      3'b111: a = ALU_AND;
      default: a = ALU_ADD;
    endcase
    return a;
  endfunction

  // Register file: x0 is never written, so it stays 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && rd_WB != 5'd0) begin
      regs[rd_WB] <= Data_WB;
    end
  end

  // Combinational read ports with write-through bypass
  always_comb begin
    rd1_d = regs[rs1];
    rd2_d = regs[rs2];
    if (rs1 == 5'd0) begin
      rd1_d = '0;
    end else if (RegWrite && rd_WB == rs1) begin
      rd1_d = Data_WB;
    end
    if (rs2 == 5'd0) begin
      rd2_d = '0;
    end else if (RegWrite && rd_WB == rs2) begin
      rd2_d = Data_WB;
    end
  end

  // Immediate generation by instruction format
  always_comb begin
    imm_d = '0;
    unique case (1'b1)
      is_ld, is_iop, is_jalr:
        imm_d = {{20{instrCode[31]}}, instrCode[31:20]};
      is_st:
        imm_d = {{20{instrCode[31]}}, instrCode[31:25],
                 instrCode[11:7]};
      is_br:
        imm_d = {{19{instrCode[31]}}, instrCode[31],
                 instrCode[7], instrCode[30:25],
                 instrCode[11:8], 1'b0};
      is_lui, is_aui:
        imm_d = {instrCode[31:12], 12'b0};
      is_jal:
        imm_d = {{11{instrCode[31]}}, instrCode[31],
                 instrCode[19:12], instrCode[20],
                 instrCode[30:21], 1'b0};
      default:
        imm_d = '0;
    endcase
  end

  // ALU operation select
  always_comb begin
    alu_d = ALU_ADD;
    unique case (1'b1)
      is_r:    alu_d = f3_alu(f3, b30, 1'b1);
      is_iop:  alu_d = f3_alu(f3, b30, 1'b0);
      is_br:   alu_d = ALU_SUB;
      default: alu_d = ALU_ADD;
    endcase
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_data_valid <= 1'b0;
      alu_ctrl        <= '0;
      immOut          <= '0;
      Read1           <= '0;
      Read2           <= '0;
      rd              <= '0;
      func3           <= '0;
      opcode          <= '0;
      PC_ID           <= '0;
    end else begin
      read_data_valid <= valid_d;
      alu_ctrl        <= alu_d;
      immOut          <= imm_d;
      Read1           <= rd1_d;
      Read2           <= rd2_d;
      rd              <= instrCode[11:7];
      func3           <= f3;
      opcode          <= op;
      PC_ID           <= PC;
    end
  end

endmodule

// File: tb/tb_id.sv
// Scoreboard bench for the decode stage: a reference model predicts
// each captured bundle, a monitor compares after every rising edge.
module tb_id;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        RegWrite = 1'b0;
  logic [4:0]  rd_WB = '0;
  logic [31:0] Data_WB = '0;
  logic [31:0] instrCode = '0;
  logic [31:0] PC = '0;
  logic        read_data_valid;
  logic [3:0]  alu_ctrl;
  logic [31:0] immOut;
  logic [31:0] Read1;
  logic [31:0] Read2;
  logic [4:0]  rd;
  logic [2:0]  func3;
  logic [6:0]  opcode;
  logic [31:0] PC_ID;

  id dut (
    .clk(clk), .rst(rst), .RegWrite(RegWrite),
    .rd_WB(rd_WB), .Data_WB(Data_WB),
    .instrCode(instrCode), .PC(PC),
    .read_data_valid(read_data_valid),
    .alu_ctrl(alu_ctrl), .immOut(immOut),
    .Read1(Read1), .Read2(Read2), .rd(rd),
    .func3(func3), .opcode(opcode), .PC_ID(PC_ID)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [3:0]  alu;
    logic [31:0] imm;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  op;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mregs [32];
  int          n_vec = 0;
  int          n_bad = 0;

  logic [6:0] valid_ops [9] = '{
    7'b0110011, 7'b0010011, 7'b0000011,
    7'b0100011, 7'b1100011, 7'b1101111,
    7'b1100111, 7'b0110111, 7'b0010111};

  function automatic exp_t model(
    input logic [31:0] i, input logic [31:0] pc,
    input logic we, input logic [4:0] wi,
    input logic [31:0] wd);
    exp_t e;
    logic [6:0] o;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic [3:0] base [8];
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    o   = i[6:0];
    i12 = i[31:20];
    s12 = {i[31:25], i[11:7]};
    b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    e = '0;
    e.op = o;
    e.rd = i[11:7];
    e.f3 = i[14:12];
    e.pc = pc;
    foreach (valid_ops[k]) if (valid_ops[k] == o) e.v = 1'b1;
    case (o)
      7'b0000011, 7'b0010011, 7'b1100111: e.imm = 32'(i12);
      7'b0100011: e.imm = 32'(s12);
      7'b1100011: e.imm = 32'(b13);
      7'b0110111, 7'b0010111: e.imm = i & 32'hFFFFF000;
      7'b1101111: e.imm = 32'(j21);
      default: e.imm = 0;
    endcase
    e.alu = 4'd0;
    if (o == 7'b0110011 || o == 7'b0010011) begin
      e.alu = base[i[14:12]];
      if (i[30] && i[14:12] == 3'd5) e.alu = 4'd7;
      if (i[30] && i[14:12] == 3'd0 && o == 7'b0110011)
        e.alu = 4'd1;
    end else if (o == 7'b1100011) begin
      e.alu = 4'd1;
    end
    e.r1 = (i[19:15] == 0) ? 0 :
           (we && wi == i[19:15]) ? wd : mregs[i[19:15]];
    e.r2 = (i[24:20] == 0) ? 0 :
           (we && wi == i[24:20]) ? wd : mregs[i[24:20]];
    return e;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Drive one instruction at the falling edge and predict its bundle
  task automatic step(input logic [31:0] i, input logic [31:0] pc,
                      input logic we, input logic [4:0] wi,
                      input logic [31:0] wd);
    @(negedge clk);
    instrCode = i;
    PC = pc;
    RegWrite = we;
    rd_WB = wi;
    Data_WB = wd;
    sb.push_back(model(i, pc, we, wi, wd));
    if (we && wi != 0) mregs[wi] = wd;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_outs"},
        {27'd0, read_data_valid, alu_ctrl}, 32'd0);
    chk({nm, "_imm"}, immOut, 0);
    chk({nm, "_r1r2"}, Read1 | Read2, 0);
    chk({nm, "_fld"}, {17'd0, rd, func3, opcode}, 0);
    chk({nm, "_pc"}, PC_ID, 0);
  endtask

  // Reset while writes are attempted; mid=1 hits between edges
  task automatic do_reset(input bit mid);
    if (mid) #2;
    else @(negedge clk);
    rst = 1'b1;
    sb.delete();
    foreach (mregs[k]) mregs[k] = 0;
    RegWrite = 1'b1;
    rd_WB = 5'd7;
    Data_WB = $urandom;
    instrCode = $urandom;
    PC = $urandom;
    #1 chk_zero(mid ? "rst_mid" : "rst");
    repeat (2) @(negedge clk);
    RegWrite = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: compare each captured bundle against the scoreboard
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (!rst && sb.size() > 0) begin
      e = sb.pop_front();
      a = {read_data_valid, alu_ctrl, immOut, Read1, Read2,
           rd, func3, opcode, PC_ID};
      n_vec++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL idex: got %h expected %h (instr %h)",
                 a, e, instrCode);
      end
    end
  end

  task automatic post(input string nm,
                      input logic [31:0] act_sel,
                      input logic [31:0] req);
    chk(nm, act_sel, req);
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  wi;
    foreach (mregs[k]) mregs[k] = 0;
    repeat (2) @(negedge clk);
    #1 chk_zero("por");
    rst = 1'b0;

    step(32'h00A302B3, 32'h10000000, 0, 0, 0);
    @(posedge clk); #2;
    chk("add_op", {25'd0, opcode}, 32'h33);
    chk("add_alu", {28'd0, alu_ctrl}, 0);
    chk("add_pc", PC_ID, 32'h10000000);
    chk("add_v", {31'd0, read_data_valid}, 1);

    step(32'h00000013, 32'h4, 1, 5'd2, 32'h00F0F0F0);
    step(32'h00010133, 32'h8, 0, 0, 0);
    @(posedge clk); #2;
    chk("wb_r1", Read1, 32'h00F0F0F0);
    chk("wb_r2", Read2, 0);

    step(32'h00100113, 32'hC, 0, 0, 0);
    @(posedge clk); #2;
    chk("addi_imm", immOut, 1);
    chk("addi_rd", {27'd0, rd}, 2);

    step(32'h00030013, 32'h10, 1, 5'd6, 32'h12345678);
    @(posedge clk); #2;
    chk("bypass", Read1, 32'h12345678);

    step(32'h00000013, 32'h14, 1, 5'd0, 32'hFFFFFFFF);
    step(32'h00000033, 32'h18, 0, 0, 0);
    @(posedge clk); #2;
    chk("x0", Read1 | Read2, 0);

    step(32'hFE000EE3, 32'h1C, 0, 0, 0);
    @(posedge clk); #2;
    chk("beq_imm", immOut, 32'hFFFFFFFC);
    chk("beq_alu", {28'd0, alu_ctrl}, 1);

    step(32'h40735293, 32'h20, 0, 0, 0);
    @(posedge clk); #2;
    chk("srai", {28'd0, alu_ctrl}, 7);

    step(32'h00000000, 32'h24, 0, 0, 0);
    @(posedge clk); #2;
    chk("zero_v", {31'd0, read_data_valid}, 0);

    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      if ($urandom_range(9) != 0)
        ins[6:0] = valid_ops[$urandom_range(8)];
      wi = 5'($urandom);
      if ($urandom_range(3) == 0) wi = ins[19:15];
      if ($urandom_range(7) == 0) wi = 0;
      step(ins, $urandom, 1'($urandom), wi, $urandom);
      if (n == 150) do_reset(1'b1);
    end

    do_reset(1'b0);
    for (int r = 0; r < 32; r++) begin
      ins = 32'h00000033;
      ins[19:15] = 5'(r);
      ins[24:20] = 5'(31 - r);
      step(ins, 32'(r), 0, 0, 0);
    end
    @(posedge clk); #2;
    chk("sb_drain", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
